// File: rtl/updown_counter.sv
// Modulo-MODULUS up/down counter with synchronous clear, clamped preset load and enable.
// Define UPDOWN_SEG7_EN to add the seg port with a hex 7-segment decode of q[3:0].
module updown_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             up,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             co
`ifdef UPDOWN_SEG7_EN
   ,output logic [6:0]       seg
`endif
);

    localparam logic [WIDTH-1:0] QMAX = WIDTH'(MODULUS - 1);
    // One extra bit so MODULUS == 2**WIDTH still compares correctly.
    localparam logic [WIDTH:0]   MODW = (WIDTH + 1)'(MODULUS);

    logic at_max;
    logic at_zero;

    assign at_max  = (q == QMAX);
    assign at_zero = (q == '0);
    assign tc      = en & ((up & at_max) | (~up & at_zero));

    always_ff @(posedge clk) begin
        if (clr) begin
            q  <= '0;
            co <= 1'b0;
        end else if (ld) begin
            q  <= ({1'b0, d} < MODW) ? d : QMAX;
            co <= 1'b0;
        end else if (en) begin
            if (up) begin
                q  <= at_max ? '0 : q + WIDTH'(1);
                co <= at_max;
            end else begin
                q  <= at_zero ? QMAX : q - WIDTH'(1);
                co <= at_zero;
            end
        end else begin
            co <= 1'b0;
        end
    end

`ifdef UPDOWN_SEG7_EN
    // Segment order {g,f,e,d,c,b,a}, active-high.
    always_comb begin
        seg = 7'h00;
        case (q[3:0])
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
            default: seg = 7'h00;
        endcase
    end
`endif

endmodule

// File: tb/tb_updown_counter.sv
// Bench for updown_counter: directed literal checks, randomized run against a
// modular-arithmetic model, and a two-stage decade cascade.
module tb_updown_counter;

    localparam int W = 4;
    localparam int M = 10;

    logic         clk = 1'b0;
    logic         clr = 1'b0, en = 1'b0, up = 1'b0, ld = 1'b0;
    logic [W-1:0] d = '0;
    logic [W-1:0] q;
    logic         tc, co;

    int npass = 0;
    int ntotal = 0;

    always #5 clk = ~clk;

`ifdef UPDOWN_SEG7_EN
    logic [6:0] seg, seg_c0, seg_c1;
`endif

    updown_counter #(.WIDTH(W), .MODULUS(M)) dut (
        .clk(clk), .clr(clr), .en(en), .up(up), .ld(ld), .d(d),
        .q(q), .tc(tc), .co(co)
`ifdef UPDOWN_SEG7_EN
       ,.seg(seg)
`endif
    );

    // two-digit cascade: units stage tc drives tens stage en
    logic         cclr = 1'b0, cen = 1'b0;
    logic [W-1:0] cq0, cq1;
    logic         ctc0, ctc1, cco0, cco1;

    updown_counter #(.WIDTH(W), .MODULUS(M)) c0 (
        .clk(clk), .clr(cclr), .en(cen), .up(1'b1), .ld(1'b0), .d('0),
        .q(cq0), .tc(ctc0), .co(cco0)
`ifdef UPDOWN_SEG7_EN
       ,.seg(seg_c0)
`endif
    );

    updown_counter #(.WIDTH(W), .MODULUS(M)) c1 (
        .clk(clk), .clr(cclr), .en(ctc0), .up(1'b1), .ld(1'b0), .d('0),
        .q(cq1), .tc(ctc1), .co(cco1)
`ifdef UPDOWN_SEG7_EN
       ,.seg(seg_c1)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    // Behavioural model: count value as an integer mod M
    int mq = 0;
    bit mco = 1'b0;
    bit known = 1'b0;

    always @(posedge clk) begin
        if (clr) begin
            mq = 0; mco = 1'b0; known = 1'b1;
        end else if (ld) begin
            mq = (int'(d) < M) ? int'(d) : M - 1;
            mco = 1'b0;
        end else if (en && up) begin
            mco = (mq == M - 1);
            mq = (mq + 1) % M;
        end else if (en) begin
            mco = (mq == 0);
            mq = (mq + M - 1) % M;
        end else begin
            mco = 1'b0;
        end
    end

`ifdef UPDOWN_SEG7_EN
    function automatic logic [6:0] hex7(input int v);
        logic [6:0] t [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        return t[v % 16];
    endfunction
`endif

    // Compare process: every cycle once the model is defined
    always @(posedge clk) begin
        #2;
        if (known) begin
            chk("q", 32'(q), 32'(mq));
            chk("co", 32'(co), 32'(mco));
            chk("tc", 32'(tc), 32'(en & ((up & (mq == M - 1)) | (~up & (mq == 0)))));
`ifdef UPDOWN_SEG7_EN
            chk("seg", 32'(seg), 32'(hex7(mq)));
`endif
        end
    end

    // Apply inputs at negedge, return 3 time units after the following posedge.
    task automatic tick(input logic c, input logic l, input logic e, input logic u, input int dv);
        @(negedge clk);
        clr = c; ld = l; en = e; up = u; d = W'(dv);
        @(posedge clk);
        #3;
    endtask

    initial begin
        // reset dominates ld and en
        tick(1, 1, 1, 1, 5);
        tick(1, 1, 1, 1, 5);
        chk("rst_q", 32'(q), 0);
        chk("rst_co", 32'(co), 0);
        chk("rst_tc", 32'(tc), 0);

        // count up 12 edges from 0
        for (int i = 1; i <= 12; i++) begin
            tick(0, 0, 1, 1, 0);
            if (i == 9) begin
                chk("up_q9", 32'(q), 9);
                chk("up_tc9", 32'(tc), 1);
                chk("up_co9", 32'(co), 0);
            end
            if (i == 10) begin
                chk("up_wrap_q", 32'(q), 0);
                chk("up_wrap_co", 32'(co), 1);
            end
        end
        chk("up_q12", 32'(q), 2);
        chk("up_co12", 32'(co), 0);

        // count down from 0
        tick(1, 0, 0, 0, 0);
        chk("dn_tc0", 32'(tc), 0);
        tick(0, 0, 1, 0, 0);
        chk("dn_wrap_q", 32'(q), 9);
        chk("dn_wrap_co", 32'(co), 1);
        tick(0, 0, 1, 0, 0);
        chk("dn_q8", 32'(q), 8);
        chk("dn_co8", 32'(co), 0);
        tick(0, 0, 1, 0, 0);
        chk("dn_q7", 32'(q), 7);

        // load and clamp
        tick(0, 1, 1, 0, 7);
        chk("ld7_q", 32'(q), 7);
        chk("ld7_co", 32'(co), 0);
        tick(0, 1, 1, 1, 12);
        chk("ld12_q", 32'(q), 9);
        tick(0, 1, 0, 1, 15);
        chk("ld15_q", 32'(q), 9);

        // hold
        tick(0, 1, 0, 0, 4);
        for (int i = 0; i < 5; i++) tick(0, 0, 0, 1, 0);
        chk("hold_q", 32'(q), 4);
        chk("hold_co", 32'(co), 0);
        chk("hold_tc", 32'(tc), 0);

        // clr and ld at a wrap edge
        tick(0, 1, 0, 1, 9);
        tick(1, 0, 1, 1, 0);
        chk("clrwrap_q", 32'(q), 0);
        chk("clrwrap_co", 32'(co), 0);
        tick(0, 1, 0, 1, 9);
        tick(0, 1, 1, 1, 3);
        chk("ldwrap_q", 32'(q), 3);
        chk("ldwrap_co", 32'(co), 0);

        // reversal at boundary
        tick(0, 1, 0, 0, 0);
        tick(0, 0, 1, 1, 0);
        chk("rev_q", 32'(q), 1);
        chk("rev_co", 32'(co), 0);

        // randomized run against the model
        for (int i = 0; i < 600; i++) begin
            tick(($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 3) != 0), $urandom_range(0, 1), $urandom_range(0, 15));
        end
        tick(0, 0, 0, 0, 0);

        // cascade 00..99 then wrap
        @(negedge clk); cclr = 1'b1;
        @(negedge clk); cclr = 1'b0; cen = 1'b1;
        for (int i = 1; i <= 101; i++) begin
            @(posedge clk); #3;
            chk("casc", 32'(int'(cq1) * 10 + int'(cq0)), 32'(i % 100));
            if (i == 99) chk("casc_tc1", 32'(ctc1), 1);
            if (i == 100) chk("casc_co1", 32'(cco1), 1);
        end
        cen = 1'b0;

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
